// File: rtl/pixel_op_pkg.sv
// ---------------------------------------------------------------------------
// pixel_op_pkg
// Shared definitions for the pixel stream processor: the run-time operation
// codes and the width of the mode field.
//
// Optional feature macro (consumed by pixel_stream_op): PIXEL_THRESH_EN
// ---------------------------------------------------------------------------
package pixel_op_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_BYPASS = 3'd0,
    MODE_BRIGHT = 3'd1,
    MODE_GRAY   = 3'd2,
    MODE_INVERT = 3'd3,
    MODE_THRESH = 3'd4
  } pixel_mode_e;

endpackage

// File: rtl/pixel_stream_op_if.sv
// ---------------------------------------------------------------------------
// pixel_stream_op_if
// Groups the pixel input handshake, the pixel output handshake with its frame
// position tags, and the frame_done pulse.
//
// Signals
//   in_valid / in_ready / in_data      : pixel into the processor
//   out_valid / out_ready / out_data   : processed pixel out
//   out_sof / out_eol / out_eof        : position tags, qualified by out_valid
//   frame_done                         : pulse while the EOF pixel transfers out
// Modports
//   master : the side that feeds pixels in and consumes pixels out
//   slave  : the processor itself
// ---------------------------------------------------------------------------
interface pixel_stream_op_if #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3
);
  localparam int PIX_W = DATA_W * CHANNELS;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;
  logic             frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof, frame_done
  );

endinterface

// File: rtl/pixel_pipe_stage.sv
// ---------------------------------------------------------------------------
// pixel_pipe_stage
// One valid/ready register slice. Accepts a new word whenever it is empty or
// its current word leaves on the same edge, so a chain of these runs at one
// word per cycle.
//
// Ports
//   clk_i        clock, rising edge
//   srst_i       synchronous active-high reset (empties the slice)
//   in_valid_i   upstream word valid
//   in_ready_o   slice can take a word this cycle
//   in_data_i    upstream word (W bits)
//   out_valid_o  slice holds a word
//   out_ready_i  downstream takes the word
//   out_data_o   held word (W bits)
// ---------------------------------------------------------------------------
module pixel_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // Ready also when the held word drains this edge: back-to-back flow.
  assign in_ready_o  = !full_q || out_ready_i;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_valid_i && in_ready_o) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (out_ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pixel_stream_op.sv
// ---------------------------------------------------------------------------
// pixel_stream_op
// Streaming pixel processor. Each accepted pixel is tagged with its frame
// position, transformed by the mode captured at the start of its frame, and
// emitted through two register slices (2-cycle latency, 1 pixel/cycle).
//
// Ports
//   HCLK        clock, rising edge
//   HRESET      synchronous active-high reset
//   mode        operation code, captured with the first pixel of a frame
//   bright_val  brightness offset / threshold level, captured with mode
//   bright_sub  1: subtract offset, 0: add offset, captured with mode
//   s           pixel_stream_op_if.slave: in/out handshakes, tags, frame_done
//
// Optional feature: define PIXEL_THRESH_EN to enable mode 4 (THRESH).
// Without it, code 4 passes pixels through unchanged.
// ---------------------------------------------------------------------------
module pixel_stream_op
  import pixel_op_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int IMG_W    = 768,
  parameter int IMG_H    = 512
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [MODE_W-1:0] mode,
  input  logic [DATA_W-1:0] bright_val,
  input  logic              bright_sub,
  pixel_stream_op_if.slave  s
);

  localparam int PIX_W = DATA_W * CHANNELS;
  localparam int PAY_W = PIX_W + 3;
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Frame position and the per-frame configuration.
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [DATA_W-1:0] bval_q, bval_d;
  logic              bsub_q, bsub_d;

  logic              in_xfer;
  logic              tag_sof, tag_eol, tag_eof;
  logic [MODE_W-1:0] mode_eff;
  logic [DATA_W-1:0] bval_eff;
  logic              bsub_eff;

  assign in_xfer = s.in_valid && s.in_ready;
  assign tag_sof = (x_q == '0) && (y_q == '0);
  assign tag_eol = (x_q == XW'(IMG_W - 1));
  assign tag_eof = tag_eol && (y_q == YW'(IMG_H - 1));

  // The first pixel of a frame already uses the values being captured.
  assign mode_eff = tag_sof ? mode       : mode_q;
  assign bval_eff = tag_sof ? bright_val : bval_q;
  assign bsub_eff = tag_sof ? bright_sub : bsub_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    bval_d = bval_q;
    bsub_d = bsub_q;
    if (in_xfer) begin
      if (tag_sof) begin
        mode_d = mode;
        bval_d = bright_val;
        bsub_d = bright_sub;
      end
      if (tag_eof) begin
        x_d = '0;
        y_d = '0;
      end else if (tag_eol) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= MODE_BYPASS;
      bval_q <= '0;
      bsub_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      bval_q <= bval_d;
      bsub_q <= bsub_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-mode results, all computed in parallel; one is selected below.
  // -------------------------------------------------------------------------
  logic [PIX_W-1:0] bright_pix;
  logic [PIX_W-1:0] invert_pix;
  logic [PIX_W-1:0] gray_pix;
  logic [PIX_W-1:0] proc_pix;
`ifdef PIXEL_THRESH_EN
  logic [PIX_W-1:0] thresh_pix;
`endif

  generate
    if (CHANNELS == 3) begin : g_luma
      // Weighted sum needs two extra bits; after >>2 it always fits DATA_W.
      logic [DATA_W+1:0] luma_sum;
      logic [DATA_W-1:0] luma;
      assign luma_sum = {2'b00, s.in_data[DATA_W-1:0]}
                      + {1'b0, s.in_data[2*DATA_W-1:DATA_W], 1'b0}
                      + {2'b00, s.in_data[3*DATA_W-1:2*DATA_W]};
      assign luma     = DATA_W'(luma_sum >> 2);
      assign gray_pix = {CHANNELS{luma}};
    end else begin : g_no_luma
      assign gray_pix = s.in_data;
    end
  endgenerate

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DATA_W-1:0] ch;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W-1:0] bright_ch;

    assign ch      = s.in_data[gi*DATA_W +: DATA_W];
    assign add_sum = {1'b0, ch} + {1'b0, bval_eff};

    // Saturate both ways instead of wrapping.
    assign bright_ch = bsub_eff ? ((ch >= bval_eff) ? (ch - bval_eff) : '0)
                                : (add_sum[DATA_W] ? '1 : add_sum[DATA_W-1:0]);

    assign bright_pix[gi*DATA_W +: DATA_W] = bright_ch;
    assign invert_pix[gi*DATA_W +: DATA_W] = ~ch;
`ifdef PIXEL_THRESH_EN
    // gray_pix carries luminance in every channel for 3-channel pixels and
    // the raw channel otherwise, which is exactly the threshold source.
    assign thresh_pix[gi*DATA_W +: DATA_W] =
        (gray_pix[gi*DATA_W +: DATA_W] >= bval_eff) ? '1 : '0;
`endif
  end

  always_comb begin
    proc_pix = s.in_data;
    case (mode_eff)
      MODE_BRIGHT: proc_pix = bright_pix;
      MODE_GRAY:   proc_pix = (CHANNELS == 3) ? gray_pix : s.in_data;
      MODE_INVERT: proc_pix = invert_pix;
`ifdef PIXEL_THRESH_EN
      MODE_THRESH: proc_pix = thresh_pix;
`endif
      default:     proc_pix = s.in_data;
    endcase
  end

  // -------------------------------------------------------------------------
  // Two register slices: stage 1 holds the arithmetic result, stage 2 is the
  // output register. Tags ride in the payload next to the pixel.
  // -------------------------------------------------------------------------
  logic [PAY_W-1:0] s1_in, s1_out, s2_out;
  logic             s1_valid, s1_ready;

  assign s1_in = {tag_sof, tag_eol, tag_eof, proc_pix};

  pixel_pipe_stage #(.W(PAY_W)) u_stage1 (
    .clk_i       (HCLK),
    .srst_i      (HRESET),
    .in_valid_i  (s.in_valid),
    .in_ready_o  (s.in_ready),
    .in_data_i   (s1_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s1_ready),
    .out_data_o  (s1_out)
  );

  pixel_pipe_stage #(.W(PAY_W)) u_stage2 (
    .clk_i       (HCLK),
    .srst_i      (HRESET),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s1_ready),
    .in_data_i   (s1_out),
    .out_valid_o (s.out_valid),
    .out_ready_i (s.out_ready),
    .out_data_o  (s2_out)
  );

  assign s.out_data   = s2_out[PIX_W-1:0];
  assign s.out_sof    = s2_out[PIX_W+2];
  assign s.out_eol    = s2_out[PIX_W+1];
  assign s.out_eof    = s2_out[PIX_W];
  assign s.frame_done = s.out_valid && s.out_ready && s2_out[PIX_W];

endmodule

// File: tb/tb_pixel_stream_op.sv
module tb_pixel_stream_op;
  import pixel_op_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [7:0] bright_val = 8'd0;
  logic       bright_sub = 1'b0;

  pixel_stream_op_if #(.DATA_W(8), .CHANNELS(3)) bus ();

  pixel_stream_op #(.DATA_W(8), .CHANNELS(3), .IMG_W(4), .IMG_H(2)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .mode       (mode),
    .bright_val (bright_val),
    .bright_sub (bright_sub),
    .s          (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_bad = 0;
  int   in_idx = 0;
  int   out_no = 0;
  int   fd_cnt = 0;
  bit   mon_en = 1'b1;
  bit   rand_en = 1'b0;
  bit   rdy_force = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {b, g, r};
  endfunction

  // out_ready driver: moves 2 time units after the edge, away from other drives.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge HCLK);
      #2;
      bus.out_ready = rand_en ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Output scoreboard: one line per output transfer.
  always @(negedge HCLK) begin
    if (bus.frame_done) fd_cnt++;
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_out", 32'(bus.out_valid), 32'd0);
      end else begin
        mon_e = expq.pop_front();
        $display("out #%0d data=%h sof=%b eol=%b eof=%b done=%b",
                 out_no, bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof, bus.frame_done);
        chk("out_data", 32'(bus.out_data), 32'(mon_e.d));
        chk("out_sof", 32'(bus.out_sof), 32'(mon_e.sof));
        chk("out_eol", 32'(bus.out_eol), 32'(mon_e.eol));
        chk("out_eof", 32'(bus.out_eof), 32'(mon_e.eof));
        chk("frame_done", 32'(bus.frame_done), 32'(mon_e.eof));
        out_no++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the input transfer.
  task automatic send(input logic [23:0] pix, input logic [23:0] exp);
    int n = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = pix;
    @(negedge HCLK);
    while (!bus.in_ready && n < 500) begin
      @(negedge HCLK);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    e.d   = exp;
    e.sof = (in_idx == 0);
    e.eol = (in_idx % 4 == 3);
    e.eof = (in_idx == 7);
    expq.push_back(e);
    in_idx = (in_idx + 1) % 8;
    @(posedge HCLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [23:0] pix, input logic [23:0] exp, input int n);
    for (int i = 0; i < n; i++) send(pix, exp);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  logic [23:0] p;
  logic [23:0] pe;
  time t0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset held for two edges.
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_x", 32'(dut.x_q), 32'd0);
    chk("rst_y", 32'(dut.y_q), 32'd0);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;

    // Frame 1: BRIGHT add 100, latency and mid-frame config change ignored.
    mode = MODE_BRIGHT; bright_val = 8'd100; bright_sub = 1'b0;
    send(px(200, 50, 0), px(255, 150, 100));
    chk("lat1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge HCLK);
    #1;
    chk("lat2_valid", 32'(bus.out_valid), 32'd1);
    chk("lat2_data", 32'(bus.out_data), 32'(px(255, 150, 100)));
    bright_sub = 1'b1; mode = MODE_INVERT;
    t0 = $time;
    send_n(px(10, 20, 30), px(110, 120, 130), 7);
    chk("throughput_t", 32'($time - t0), 32'd70);
    drain();
    chk("fd_after_f1", 32'(fd_cnt), 32'd1);

    // Frame 2: BRIGHT subtract 100.
    mode = MODE_BRIGHT; bright_val = 8'd100; bright_sub = 1'b1;
    send(px(200, 50, 0), px(100, 0, 0));
    send_n(px(150, 100, 99), px(50, 0, 0), 7);

    // Frame 3: GRAY.
    mode = MODE_GRAY;
    send(px(10, 20, 30), px(20, 20, 20));
    send_n(px(255, 255, 255), px(255, 255, 255), 7);

    // Frame 4: INVERT.
    mode = MODE_INVERT;
    send_n(px(8'h00, 8'h7F, 8'hFF), px(8'hFF, 8'h80, 8'h00), 8);
    drain();
    chk("fd_after_f4", 32'(fd_cnt), 32'd4);

    // Frame 5: BYPASS with random out_ready.
    rand_en = 1'b1;
    mode = MODE_BYPASS;
    for (int i = 0; i < 8; i++) begin
      p = px(8'(i), 8'(i + 16), 8'(i + 32));
      send(p, p);
    end
    drain();
    chk("fd_after_f5", 32'(fd_cnt), 32'd5);

    // Frames 6 and 7: switch to INVERT at pixel 3 of frame 6.
    mode = MODE_BYPASS;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) mode = MODE_INVERT;
      p = px(8'(i * 3), 8'h55, 8'hAA);
      send(p, p);
    end
    for (int i = 0; i < 8; i++) begin
      p  = px(8'(i * 3), 8'h55, 8'hAA);
      pe = ~p;
      send(p, pe);
    end
    drain();
    rand_en = 1'b0;
    chk("fd_after_f7", 32'(fd_cnt), 32'd7);

    // Frame 8: mode 4 with level 128.
    mode = 3'd4; bright_val = 8'd128; bright_sub = 1'b0;
`ifdef PIXEL_THRESH_EN
    send(px(127, 127, 127), px(0, 0, 0));
    send(px(128, 128, 128), px(255, 255, 255));
    send(px(100, 200, 100), px(255, 255, 255));
    send_n(px(200, 0, 56), px(0, 0, 0), 5);
`else
    send(px(127, 127, 127), px(127, 127, 127));
    send(px(128, 128, 128), px(128, 128, 128));
    send(px(100, 200, 100), px(100, 200, 100));
    send_n(px(200, 0, 56), px(200, 0, 56), 5);
`endif
    drain();
    chk("fd_after_f8", 32'(fd_cnt), 32'd8);

    // Stall with both stages full, then reset mid-frame.
    mode = MODE_BYPASS;
    rdy_force = 1'b0;
    repeat (2) begin
      @(posedge HCLK);
      #1;
    end
    send(px(1, 2, 3), px(1, 2, 3));
    send(px(4, 5, 6), px(4, 5, 6));
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_data0", 32'(bus.out_data), 32'(px(1, 2, 3)));
    @(posedge HCLK);
    #1;
    chk("stall_data1", 32'(bus.out_data), 32'(px(1, 2, 3)));
    chk("stall_sof", 32'(bus.out_sof), 32'd1);
    mon_en = 1'b0;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_x", 32'(dut.x_q), 32'd0);
    HRESET = 1'b0;
    expq.delete();
    in_idx = 0;
    rdy_force = 1'b1;
    mon_en = 1'b1;
    send(px(7, 8, 9), px(7, 8, 9));
    drain();
    chk("fd_final", 32'(fd_cnt), 32'd8);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
